seq_pattern_tx: RTL and testbench
=================================

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 Parameter DIV, default 5, SHALL set clk cycles each serial bit is held on w (legal 2..2^26-1).
REQ-002 Parameter PAT_W, default 16, SHALL set pattern register width (legal 2..32).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  request to send; sampled only in IDLE.
REQ-006 pattern  in  PAT_W  bits to send, MSB first.
REQ-007 len  in  clog2(PAT_W)+1  number of bits to send, 1..PAT_W.
REQ-008 repeat  in  1  loop the pattern continuously.
REQ-009 stop  in  1  cancel looping; current pass completes.
REQ-010 w  out  1  serial bit stream for the sequence-detector w input.
REQ-011 bit_valid  out  1  one-cycle strobe on the first cycle each new bit is on w.
REQ-012 bit_idx  out  clog2(PAT_W)  index of the bit currently on w, 0 = first.
REQ-013 busy  out  1  transmission in progress.
REQ-014 done  out  1  one-cycle pulse after the final bit of the final pass.
REQ-015 z_exp  out  1  expected detector z, per REQ-027.

Function
REQ-016 FSM states SHALL be IDLE and SEND only.
REQ-017 IDLE→SEND SHALL occur when start=1 and 1<=len<=PAT_W; otherwise start is ignored.
REQ-018 On acceptance, pattern, len and repeat SHALL be latched; later input changes SHALL have no effect, except stop (REQ-023).
REQ-019 Cycle after acceptance: w=pattern[PAT_W-1], bit_idx=0, bit_valid=1, busy=1.
REQ-020 Each bit SHALL be held exactly DIV cycles via a divider counting 0..DIV-1 and cleared on acceptance.
REQ-021 Bit k SHALL be pattern[PAT_W-1-k]; bit_idx increments by 1 per bit; bit_valid pulses once per bit.
REQ-022 After the DIV-th cycle of bit len-1, with latched repeat=1, bit 0 SHALL follow with no gap cycle and bit_valid=1.
REQ-023 stop=1 in SEND SHALL clear latched repeat; the pass in progress completes, then SEND exits.
REQ-024 After the DIV-th cycle of bit len-1, with latched repeat=0, SEND→IDLE: done=1 for one cycle, busy=0, w=0 that same cycle.
REQ-025 In IDLE: w=0, bit_valid=0, bit_idx=0, busy=0, z_exp=0.
REQ-026 start while busy SHALL be ignored; start held high through done SHALL be accepted in the cycle done is high, giving back-to-back passes.
REQ-027 z_exp: a run counter, saturating at 4, SHALL be set to 1 on the first bit of an accepted transmission.
- On each later bit_valid, it increments if the new bit equals the previous bit, else reloads to 1.
- z_exp = 1 while run=4 in SEND.
- Runs SHALL carry across repeat wrap.

Reset
REQ-028 reset=1 SHALL force IDLE, clear the divider, run counter and latches, and drive w, bit_valid, bit_idx, busy, done and z_exp to 0 on the next edge.
REQ-029 reset SHALL take priority over start, and SHALL abort SEND mid-bit without a done pulse.

Configuration
REQ-030 With macro SEQ_TX_ZEXP_EN defined, the run counter and z_exp logic of REQ-027 SHALL be built.
REQ-031 Without SEQ_TX_ZEXP_EN, z_exp SHALL be constant 0 and no run-counter logic SHALL exist; all other behaviour is unchanged.

Verification
REQ-032 DIV=5, PAT_W=16, pattern=16'hF0F0, len=8, repeat=0, start pulse.
- w = 1,1,1,1,0,0,0,0, each bit 5 cycles; 8 bit_valid pulses.
- done exactly 41 cycles after the start edge.
- z_exp=1 during bits 3 and 7 only (SEQ_TX_ZEXP_EN defined).
REQ-033 Same stimulus with len=0, and with len=17 → no busy, w stays 0, no done.
REQ-034 pattern=16'hA000, len=3, repeat=1 → w = 1,0,1,1,0,1,... with no gap at wrap; z_exp never 1.
- Assert stop during the second pass → exactly one done, at the end of the second pass.
REQ-035 reset asserted at cycle 12 of a pattern=16'hFFFF, len=16 send → all outputs 0 next cycle, no done.
- A fresh start then sends from bit 0.
REQ-036 start held high continuously, len=2 → done and re-acceptance in the same cycle.
- Bit 0 of the next pass appears the following cycle; second start pulses while busy are ignored.
REQ-037 Without SEQ_TX_ZEXP_EN, rerun REQ-032 → w, done and timing identical; z_exp constantly 0.

Source files
------------

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serialises a latched pattern MSB-first onto w, DIV clk cycles per bit,
// optionally looping, as stimulus for a sequence detector. Optional macro SEQ_TX_ZEXP_EN
// builds the run counter that produces z_exp (expected detector output for runs of 4).
// Latency: first bit on w the cycle after start is accepted; done one cycle after the last bit.
// Backpressure: none; start is only sampled in IDLE, ignored while busy.
//
// Ports:
//   clk, reset         : single clock, synchronous active-high reset
//   start              : request to send (IDLE only; needs 1 <= len <= PAT_W)
//   pattern, len       : bits to send (MSB first) and bit count
//   repeat_mode, stop  : loop the pattern continuously / cancel looping after current pass
//   w, bit_valid       : serial bit and first-cycle-of-bit strobe
//   bit_idx, busy, done: current bit index, transmission active, end-of-transmission pulse
//   z_exp              : high while the current run of equal bits has reached 4
module seq_pattern_tx #(
    parameter int DIV   = 5,
    parameter int PAT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [PAT_W-1:0]         pattern,
    input  logic [$clog2(PAT_W):0]   len,
    input  logic                     repeat_mode,
    input  logic                     stop,
    output logic                     w,
    output logic                     bit_valid,
    output logic [$clog2(PAT_W)-1:0] bit_idx,
    output logic                     busy,
    output logic                     done,
    output logic                     z_exp
);

    localparam int LW = $clog2(PAT_W) + 1;
    localparam int IW = $clog2(PAT_W);
    localparam int DW = $clog2(DIV);
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [LW-1:0] LEN_MAX   = LW'(PAT_W);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [PAT_W-1:0] pat_q;     // latched pattern, reloaded into sh_q on wrap
    logic [PAT_W-1:0] sh_q;      // current bit always sits at the MSB
    logic [LW-1:0]    len_q;
    logic             rpt_q;
    logic [IW-1:0]    idx_q;
    logic [DW-1:0]    div_q;
    logic             done_q;

    logic accept;
    logic bit_end;
    logic last_bit;
    logic wrap;

    assign accept   = (state_q == IDLE) && start && (len != '0) && (len <= LEN_MAX);
    assign bit_end  = (div_q == DIV_LAST);
    assign last_bit = ({1'b0, idx_q} == (len_q - 1'b1));
    // A stop arriving on the very last cycle of a pass still prevents the wrap.
    assign wrap     = rpt_q && !stop;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and outputs
    always_comb begin
        state_d   = state_q;
        w         = 1'b0;
        bit_valid = 1'b0;
        bit_idx   = '0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                w         = sh_q[PAT_W-1];
                bit_valid = (div_q == '0);
                bit_idx   = idx_q;
                busy      = 1'b1;
                if (bit_end && last_bit && !wrap) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign done = done_q;

    // Datapath: latches, bit shifter, index and divider
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q  <= '0;
            sh_q   <= '0;
            len_q  <= '0;
            rpt_q  <= 1'b0;
            idx_q  <= '0;
            div_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        pat_q <= pattern;
                        sh_q  <= pattern;
                        len_q <= len;
                        rpt_q <= repeat_mode;
                        idx_q <= '0;
                        div_q <= '0;
                    end
                end
                SEND: begin
                    if (stop) begin
                        rpt_q <= 1'b0;
                    end
                    if (bit_end) begin
                        div_q <= '0;
                        if (last_bit) begin
                            if (wrap) begin
                                sh_q  <= pat_q;
                                idx_q <= '0;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end else begin
                            sh_q  <= sh_q << 1;
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SEQ_TX_ZEXP_EN
    // Run length of equal consecutive bits, saturating at 4. Updated on the edge that
    // starts a new bit so it is valid for the whole bit; carries across a repeat wrap.
    logic [2:0] run_q;
    logic       next_bit;

    assign next_bit = last_bit ? pat_q[PAT_W-1] : sh_q[PAT_W-2];

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q <= '0;
        end else if (accept) begin
            run_q <= 3'd1;
        end else if ((state_q == SEND) && bit_end && (!last_bit || wrap)) begin
            if (next_bit == sh_q[PAT_W-1]) begin
                run_q <= (run_q == 3'd4) ? 3'd4 : run_q + 3'd1;
            end else begin
                run_q <= 3'd1;
            end
        end
    end

    assign z_exp = (state_q == SEND) && (run_q == 3'd4);
`else
    assign z_exp = 1'b0;
`endif

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: directed bench for seq_pattern_tx (DIV=5, PAT_W=16).
// Inputs change 1 time unit after the rising edge; outputs are checked at that same point.
// Expected z_exp follows whether SEQ_TX_ZEXP_EN is defined for the build.
module tb_seq_pattern_tx;

    localparam int DIV   = 5;
    localparam int PAT_W = 16;
`ifdef SEQ_TX_ZEXP_EN
    localparam bit ZEN = 1'b1;
`else
    localparam bit ZEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] pattern;
    logic [4:0]  len;
    logic        repeat_mode;
    logic        stop;
    logic        w;
    logic        bit_valid;
    logic [3:0]  bit_idx;
    logic        busy;
    logic        done;
    logic        z_exp;

    int n_chk = 0;
    int n_err = 0;

    seq_pattern_tx #(.DIV(DIV), .PAT_W(PAT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pattern     (pattern),
        .len         (len),
        .repeat_mode (repeat_mode),
        .stop        (stop),
        .w           (w),
        .bit_valid   (bit_valid),
        .bit_idx     (bit_idx),
        .busy        (busy),
        .done        (done),
        .z_exp       (z_exp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // All outputs at their idle values, with an expected done level.
    task automatic chk_idle(input string tag, input logic exp_done);
        chk({tag, ".w"},         w,         0);
        chk({tag, ".bit_valid"}, bit_valid, 0);
        chk({tag, ".bit_idx"},   bit_idx,   0);
        chk({tag, ".busy"},      busy,      0);
        chk({tag, ".done"},      done,      exp_done);
        chk({tag, ".z_exp"},     z_exp,     0);
    endtask

    // Checks the DIV cycles of one bit (current cycle first), advancing one edge per cycle.
    task automatic chk_bit(input string tag, input logic b, input int k, input logic z);
        for (int d = 0; d < DIV; d++) begin
            string t;
            t = $sformatf("%s.b%0d.c%0d", tag, k, d);
            chk({t, ".w"},         w,         b);
            chk({t, ".bit_valid"}, bit_valid, (d == 0));
            chk({t, ".bit_idx"},   bit_idx,   k);
            chk({t, ".busy"},      busy,      1);
            chk({t, ".done"},      done,      0);
            chk({t, ".z_exp"},     z_exp,     ZEN & z);
            step();
        end
    endtask

    // One-cycle start pulse; returns in the first cycle after the start edge.
    task automatic launch(input logic [15:0] p, input logic [4:0] l, input logic r);
        pattern     = p;
        len         = l;
        repeat_mode = r;
        start       = 1'b1;
        step();
        start       = 1'b0;
    endtask

    initial begin
        logic [7:0] f0_bits;
        reset = 1'b1; start = 1'b0; pattern = '0; len = '0; repeat_mode = 1'b0; stop = 1'b0;
        step();
        step();
        chk_idle("rst", 0);
        reset = 1'b0;
        step();

        // F0F0, len 8: 1111_0000, done 41 cycles after the start edge, z_exp on bits 3 and 7
        f0_bits = 8'b1111_0000;
        launch(16'hF0F0, 5'd8, 1'b0);
        for (int k = 0; k < 8; k++) begin
            chk_bit("f0", f0_bits[7-k], k, (k == 3) || (k == 7));
        end
        chk_idle("f0.end", 1);
        step();
        chk_idle("f0.post", 0);

        // Illegal lengths are ignored
        launch(16'hF0F0, 5'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk_idle($sformatf("len0.c%0d", i), 0);
            step();
        end
        launch(16'hF0F0, 5'd17, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk_idle($sformatf("len17.c%0d", i), 0);
            step();
        end

        // A000, len 3, looping; stop during the second pass ends after that pass
        launch(16'hA000, 5'd3, 1'b1);
        chk_bit("rp1", 1'b1, 0, 1'b0);
        chk_bit("rp1", 1'b0, 1, 1'b0);
        chk_bit("rp1", 1'b1, 2, 1'b0);
        stop = 1'b1;
        chk_bit("rp2", 1'b1, 0, 1'b0);
        stop = 1'b0;
        chk_bit("rp2", 1'b0, 1, 1'b0);
        chk_bit("rp2", 1'b1, 2, 1'b0);
        chk_idle("rp.end", 1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk_idle($sformatf("rp.post%0d", i), 0);
        end

        // Reset mid-send aborts without done; a fresh start sends from bit 0
        step();
        launch(16'hFFFF, 5'd16, 1'b0);
        for (int i = 0; i < 11; i++) begin
            step();
        end
        chk("abort.busy_before", busy, 1);
        reset = 1'b1;
        step();
        chk_idle("abort.rst", 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_idle($sformatf("abort.post%0d", i), 0);
        end
        launch(16'h8000, 5'd2, 1'b0);
        chk_bit("fresh", 1'b1, 0, 1'b0);
        chk_bit("fresh", 1'b0, 1, 1'b0);
        chk_idle("fresh.end", 1);
        step();

        // start held high: re-accepted in the done cycle; pattern changes while busy are ignored
        pattern     = 16'hC000;
        len         = 5'd2;
        repeat_mode = 1'b0;
        start       = 1'b1;
        step();
        pattern     = 16'h0000;
        chk_bit("hold1", 1'b1, 0, 1'b0);
        chk_bit("hold1", 1'b1, 1, 1'b0);
        chk_idle("hold1.end", 1);
        step();
        start = 1'b0;
        chk_bit("hold2", 1'b0, 0, 1'b0);
        chk_bit("hold2", 1'b0, 1, 1'b0);
        chk_idle("hold2.end", 1);
        step();
        chk_idle("hold2.post", 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
